// File: rtl/ascon_block_packer_pkg.sv
// rtl/ascon_block_packer_pkg.sv - shared constants, segment types and FSM encoding for the ASCON block packer
package ascon_block_packer_pkg;

    localparam int         RATE_BYTES_DEF = 8;
    localparam logic [7:0] PAD_BYTE       = 8'h80;

    localparam logic SEG_AD = 1'b0;
    localparam logic SEG_PT = 1'b1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        OUT  = 2'd1,
        PAD  = 2'd2
    } state_t;

endpackage

// File: rtl/ascon_block_packer_if.sv
// rtl/ascon_block_packer_if.sv - byte input stream and packed block output bundle of the ASCON block packer
interface ascon_block_packer_if #(
    parameter int RATE_BYTES = 8
);
    localparam int CW = $clog2(RATE_BYTES + 1);

    logic [7:0]              s_data;
    logic                    s_valid;
    logic                    s_ready;
    logic                    s_last;
    logic                    s_type;
    logic                    s_empty;

    logic [8*RATE_BYTES-1:0] m_block;
    logic [CW-1:0]           m_bytes;
    logic                    m_type;
    logic                    m_last;
    logic                    m_valid;
    logic                    m_ready;

    logic                    err;

    // Packer side: consumes bytes, produces blocks.
    modport slave (
        input  s_data, s_valid, s_last, s_type, s_empty, m_ready,
        output s_ready, m_block, m_bytes, m_type, m_last, m_valid, err
    );

    // Environment side: feeds bytes, absorbs blocks.
    modport master (
        output s_data, s_valid, s_last, s_type, s_empty, m_ready,
        input  s_ready, m_block, m_bytes, m_type, m_last, m_valid, err
    );

endinterface

// File: rtl/ascon_block_packer.sv
// rtl/ascon_block_packer.sv - packs AD/PT bytes into big-endian rate blocks with ASCON 10* padding
module ascon_block_packer
    import ascon_block_packer_pkg::*;
#(
    parameter int RATE_BYTES = RATE_BYTES_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    ascon_block_packer_if.slave  bus
);

    localparam int CW = $clog2(RATE_BYTES + 1);
    localparam int BW = 8 * RATE_BYTES;
    localparam int IW = $clog2(BW);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [BW-1:0]   r_block;
    logic [CW-1:0]   r_bytes;
    logic            r_type;
    logic            r_last;
    logic            r_pad_pend;
    logic            r_in_seg;
    logic            r_seg_type;
    logic            r_err;

    logic            w_s_ready;
    logic            w_accept;
    logic            w_empty;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_full;
    logic [IW-1:0]   w_lsb_cur;
    logic [IW-1:0]   w_lsb_nxt;

    assign w_s_ready = rst && (r_state == FILL);
    assign w_accept  = bus.s_valid && w_s_ready;
    assign w_empty   = bus.s_last && bus.s_empty;
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_full    = (w_cnt_inc == CW'(RATE_BYTES));

    // Slot 0 is the most significant byte; the next slot only matters when the block is not full.
    assign w_lsb_cur = IW'((RATE_BYTES - 1 - int'(r_cnt)) * 8);
    assign w_lsb_nxt = IW'((RATE_BYTES - 2 - int'(r_cnt)) * 8);

    assign bus.s_ready = w_s_ready;
    assign bus.m_block = r_block;
    assign bus.m_bytes = r_bytes;
    assign bus.m_type  = r_type;
    assign bus.m_last  = r_last;
    assign bus.m_valid = (r_state == OUT) || (r_state == PAD);
    assign bus.err     = r_err;

    // Packing FSM: fill byte slots, present the block, then an optional padding-only block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= FILL;
            r_cnt      <= '0;
            r_block    <= '0;
            r_bytes    <= '0;
            r_type     <= 1'b0;
            r_last     <= 1'b0;
            r_pad_pend <= 1'b0;
            r_in_seg   <= 1'b0;
            r_seg_type <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        if (r_cnt == '0) begin
                            r_type <= bus.s_type;
                        end
                        // A type change inside an unfinished segment is flagged but the byte is still packed.
                        if (r_in_seg && (bus.s_type != r_seg_type)) begin
                            r_err <= 1'b1;
                        end
                        if (!r_in_seg) begin
                            r_seg_type <= bus.s_type;
                        end
                        r_in_seg <= !bus.s_last;
                        r_block[w_lsb_cur +: 8] <= w_empty ? PAD_BYTE : bus.s_data;

                        if (w_empty) begin
                            r_bytes <= r_cnt;
                            r_last  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= OUT;
                        end else if (w_full) begin
                            // A segment ending exactly on the rate boundary needs a separate padding block.
                            r_bytes    <= CW'(RATE_BYTES);
                            r_last     <= 1'b0;
                            r_pad_pend <= bus.s_last;
                            r_cnt      <= '0;
                            r_state    <= OUT;
                        end else if (bus.s_last) begin
                            r_block[w_lsb_nxt +: 8] <= PAD_BYTE;
                            r_bytes <= w_cnt_inc;
                            r_last  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= OUT;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end
                OUT: begin
                    if (bus.m_ready) begin
                        if (r_pad_pend) begin
                            r_block <= {PAD_BYTE, {(BW-8){1'b0}}};
                            r_bytes <= '0;
                            r_last  <= 1'b1;
                            r_state <= PAD;
                        end else begin
                            r_block <= '0;
                            r_state <= FILL;
                        end
                    end
                end
                PAD: begin
                    if (bus.m_ready) begin
                        r_pad_pend <= 1'b0;
                        r_block    <= '0;
                        r_state    <= FILL;
                    end
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_block_packer.sv
// tb/tb_ascon_block_packer.sv - scoreboard bench for the ASCON block packer
module tb_ascon_block_packer;
    import ascon_block_packer_pkg::*;

    localparam int RB = 8;
    localparam int BW = 8 * RB;
    localparam int CW = $clog2(RB + 1);

    typedef struct {
        logic [BW-1:0] block;
        int            bytes;
        logic          typ;
        logic          last;
    } exp_t;

    logic clk;
    logic rst;
    bit   rand_ready_en;
    int   n_cmp;
    int   n_bad;
    exp_t sb[$];

    ascon_block_packer_if #(.RATE_BYTES(RB)) bus ();

    ascon_block_packer #(.RATE_BYTES(RB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: split the segment into rate-sized chunks; a short (or empty) last chunk gets 0x80 appended.
    task automatic model_push(input logic typ, input logic [7:0] d[$]);
        exp_t e;
        int   n;
        int   pos;
        int   k;
        n   = d.size();
        pos = 0;
        do begin
            k = (n - pos > RB) ? RB : (n - pos);
            e.block = '0;
            for (int i = 0; i < k; i++) e.block[(RB-1-i)*8 +: 8] = d[pos+i];
            if (k < RB) e.block[(RB-1-k)*8 +: 8] = 8'h80;
            e.bytes = k;
            e.typ   = typ;
            e.last  = (k < RB);
            sb.push_back(e);
            pos += k;
        end while (!e.last);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic typ, input logic empty);
        int waited;
        waited       = 0;
        bus.s_data   = d;
        bus.s_last   = last;
        bus.s_type   = typ;
        bus.s_empty  = empty;
        bus.s_valid  = 1'b1;
        @(negedge clk);
        while (!bus.s_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.s_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL s_ready_timeout: got 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_seg(input logic typ, input logic [7:0] d[$], input bit empty_end, input bit gaps);
        for (int i = 0; i < d.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(d[i], (i == d.size() - 1) && !empty_end, typ, 1'b0);
        end
        if (empty_end || d.size() == 0) send_beat(8'h5A, 1'b1, typ, 1'b1);
    endtask

    // Random backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready_en) bus.m_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pop expected block on every handshake; outputs must hold while stalled.
    initial begin : monitor
        exp_t          e;
        bit            p_stall;
        logic [BW-1:0] p_block;
        logic [CW-1:0] p_bytes;
        logic          p_type;
        logic          p_last;
        p_stall = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                p_stall = 0;
            end else begin
                if (p_stall) begin
                    check("stall_valid", bus.m_valid, 1'b1);
                    check("stall_hold", {bus.m_block, bus.m_bytes, bus.m_type, bus.m_last},
                          {p_block, p_bytes, p_type, p_last});
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_block: got %0h expected none", bus.m_block);
                    end else begin
                        e = sb.pop_front();
                        check("m_block", bus.m_block, e.block);
                        check("m_bytes", bus.m_bytes, e.bytes);
                        check("m_type", bus.m_type, e.typ);
                        check("m_last", bus.m_last, e.last);
                    end
                end
                p_stall = bus.m_valid && !bus.m_ready;
                p_block = bus.m_block;
                p_bytes = bus.m_bytes;
                p_type  = bus.m_type;
                p_last  = bus.m_last;
            end
        end
    end

    initial begin : stim
        logic [7:0] d[$];
        logic       typ;
        int         n;
        int         guard;
        bit         emp_end;

        n_cmp = 0;
        n_bad = 0;
        rand_ready_en = 0;
        rst = 1'b0;
        bus.s_data = 8'h00;
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
        bus.s_type = 1'b0;
        bus.s_empty = 1'b0;
        bus.m_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_s_ready", bus.s_ready, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_m_block", bus.m_block, '0);
        check("rst_m_bytes", bus.m_bytes, '0);
        check("rst_m_type", bus.m_type, 1'b0);
        check("rst_m_last", bus.m_last, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_s_ready", bus.s_ready, 1'b1);
        bus.m_ready = 1'b1;

        // 1: short AD segment, block appears the cycle after its last byte
        d = '{8'h01, 8'h02, 8'h03};
        model_push(SEG_AD, d);
        send_beat(8'h01, 1'b0, SEG_AD, 1'b0);
        send_beat(8'h02, 1'b0, SEG_AD, 1'b0);
        check("t1_no_early_valid", bus.m_valid, 1'b0);
        send_beat(8'h03, 1'b1, SEG_AD, 1'b0);
        check("t1_latency", bus.m_valid, 1'b1);

        // 2: exactly one full block of PT -> full block then padding-only block
        d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        model_push(SEG_PT, d);
        send_seg(SEG_PT, d, 1'b0, 1'b0);

        // 3: empty PT segment
        d.delete();
        model_push(SEG_PT, d);
        send_seg(SEG_PT, d, 1'b1, 1'b0);

        // 4: 12-byte AD with output stalled after the first block
        repeat (3) @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        d.delete();
        for (int i = 1; i <= 12; i++) d.push_back(8'(i));
        model_push(SEG_AD, d);
        for (int i = 0; i < 8; i++) send_beat(d[i], 1'b0, SEG_AD, 1'b0);
        repeat (5) begin
            @(negedge clk);
            check("t4_s_ready_stall", bus.s_ready, 1'b0);
            check("t4_m_valid_stall", bus.m_valid, 1'b1);
            check("t4_block_stall", bus.m_block, 64'h0102030405060708);
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        for (int i = 8; i < 12; i++) send_beat(d[i], i == 11, SEG_AD, 1'b0);

        // 5: type change inside a segment sets sticky err; bytes still packed
        d = '{8'hA1, 8'hB2};
        model_push(SEG_AD, d);
        send_beat(8'hA1, 1'b0, SEG_AD, 1'b0);
        check("t5_err_before", bus.err, 1'b0);
        send_beat(8'hB2, 1'b1, SEG_PT, 1'b0);
        check("t5_err_set", bus.err, 1'b1);
        d = '{8'hC3, 8'hD4, 8'hE5};
        model_push(SEG_PT, d);
        send_seg(SEG_PT, d, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_err_sticky", bus.err, 1'b1);

        // 6: async reset in the middle of a partial block
        for (int i = 0; i < 5; i++) send_beat(8'hF0 + 8'(i), 1'b0, SEG_AD, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("t6_m_valid_rst", bus.m_valid, 1'b0);
        check("t6_err_rst", bus.err, 1'b0);
        check("t6_s_ready_rst", bus.s_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        d = '{8'hAB, 8'hCD};
        model_push(SEG_PT, d);
        send_seg(SEG_PT, d, 1'b0, 1'b0);

        // Random segments with gaps and backpressure
        rand_ready_en = 1;
        for (int s = 0; s < 40; s++) begin
            d.delete();
            typ = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 20);
            emp_end = (n == 0) || ($urandom_range(0, 3) == 0);
            for (int i = 0; i < n; i++) d.push_back(8'($urandom));
            model_push(typ, d);
            send_seg(typ, d, emp_end, 1'b1);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        rand_ready_en = 0;
        #2;
        bus.m_ready = 1'b1;
        check("drain_empty", sb.size(), 0);
        check("final_err", bus.err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
